// File: rtl/lsu_pkg.sv
// Shared definitions for the MEM-stage load/store unit: func3 codes,
// FSM state encoding and small access-size helpers.
package lsu_pkg;

    // Load func3 codes
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    // Store func3 codes (share the size encoding of the loads)
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    typedef enum logic [1:0] {
        LSU_IDLE = 2'd0,
        LSU_REQ  = 2'd1,
        LSU_WAIT = 2'd2
    } lsu_state_t;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2
    } acc_size_t;

    // Access size from func3; unknown size codes behave as a word access.
    function automatic acc_size_t f3_size(input logic [2:0] func3);
        acc_size_t sz;
        case (func3[1:0])
            2'b00:   sz = SZ_BYTE;
            2'b01:   sz = SZ_HALF;
            default: sz = SZ_WORD;
        endcase
        return sz;
    endfunction

    // Halfwords need an even address, words a 4-byte aligned one.
    function automatic logic addr_misaligned(input acc_size_t sz, input logic [1:0] lsb);
        logic bad;
        case (sz)
            SZ_HALF: bad = lsb[0];
            SZ_WORD: bad = |lsb;
            default: bad = 1'b0;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/load_align.sv
// Combinational load-data extraction: picks the addressed byte/halfword
// out of the raw memory word and sign- or zero-extends it.
module load_align
    import lsu_pkg::*;
(
    input  logic [2:0]  func3,
    input  logic [1:0]  addr_lsb,
    input  logic [31:0] rdata,
    output logic [31:0] load_data
);

    logic [7:0]  sel_byte;
    logic [15:0] sel_half;

    // Lane select followed by extension according to func3.
    always_comb begin
        sel_byte  = rdata[{addr_lsb, 3'b000} +: 8];
        sel_half  = addr_lsb[1] ? rdata[31:16] : rdata[15:0];
        load_data = rdata;
        case (func3)
            F3_LB:   load_data = {{24{sel_byte[7]}}, sel_byte};
            F3_LH:   load_data = {{16{sel_half[15]}}, sel_half};
            F3_LBU:  load_data = {24'd0, sel_byte};
            F3_LHU:  load_data = {16'd0, sel_half};
            default: load_data = rdata;
        endcase
    end

endmodule

// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store unit: drives the req/gnt/rvalid data-memory port,
// stalls the pipeline while an access is outstanding and owns MEM/WB.
//
// state    | meaning
// ---------+----------------------------------------------------------
// LSU_IDLE | no access in flight; an aligned access requests this cycle
// LSU_REQ  | request raised but not yet granted; dmem_* held stable
// LSU_WAIT | load granted, waiting for rvalid; request dropped
module mem_stage_lsu
    import lsu_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,

    input  logic [3:0]        MEM_controller_dm_en,
    input  logic              MEM_controller_mux_rd,
    input  logic              MEM_controller_regfile_en,
    input  logic [2:0]        MEM_docoder_func3,
    input  logic [4:0]        MEM_decoder_rd_index,
    input  logic [31:0]       MEM_alu_result,
    input  logic [31:0]       MEM_write_data,

    output logic              dmem_req,
    output logic              dmem_we,
    output logic [3:0]        dmem_wstrb,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [31:0]       dmem_wdata,
    input  logic              dmem_gnt,
    input  logic              dmem_rvalid,
    input  logic [31:0]       dmem_rdata,

    output logic              mem_stall,
    output logic              misalign_err,

    output logic              WB_controller_mux_rd,
    output logic              WB_controller_regfile_en,
    output logic [4:0]        WB_decoder_rd_index,
    output logic [31:0]       WB_alu_result,
    output logic [31:0]       WB_load_data
);

    lsu_state_t  state;
    acc_size_t   acc_size;
    logic        is_store;
    logic        is_load;
    logic        access;
    logic        misaligned;
    logic        go;
    logic        complete;
    logic        load_done;
    logic [31:0] load_word;

    // Classify the instruction sitting in MEM.
    always_comb begin
        is_store   = |MEM_controller_dm_en;
        is_load    = MEM_controller_mux_rd & MEM_controller_regfile_en;
        access     = is_store | is_load;
        acc_size   = f3_size(MEM_docoder_func3);
        misaligned = access & addr_misaligned(acc_size, MEM_alu_result[1:0]);
        go         = access & ~misaligned;
    end

    // Memory-port payload is taken straight from the held MEM inputs, so it
    // stays stable across REQ without extra holding registers.
    always_comb begin
        dmem_we    = is_store;
        dmem_wstrb = MEM_controller_dm_en;
        dmem_addr  = {MEM_alu_result[ADDR_W-1:2], 2'b00};
        if (acc_size == SZ_WORD)
            dmem_wdata = MEM_write_data;
        else
            dmem_wdata = MEM_write_data << {MEM_alu_result[1:0], 3'b000};
    end

    // Request, completion and stall; everything is forced low during reset so
    // an in-flight request drops the moment rst rises.
    always_comb begin
        dmem_req = 1'b0;
        if (!rst) begin
            case (state)
                LSU_IDLE: dmem_req = go;
                LSU_REQ:  dmem_req = 1'b1;
                default:  dmem_req = 1'b0;
            endcase
        end
        load_done    = (state == LSU_WAIT) & dmem_rvalid;
        complete     = (is_store & dmem_req & dmem_gnt) | load_done;
        mem_stall    = ~rst & go & ~complete;
        misalign_err = ~rst & misaligned & (state == LSU_IDLE);
    end

    // Access sequencing; rvalid outside WAIT is ignored.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= LSU_IDLE;
        end else begin
            case (state)
                LSU_IDLE: begin
                    if (go) begin
                        if (!dmem_gnt)
                            state <= LSU_REQ;
                        else if (!is_store)
                            state <= LSU_WAIT;
                    end
                end
                LSU_REQ: begin
                    if (dmem_gnt)
                        state <= is_store ? LSU_IDLE : LSU_WAIT;
                end
                LSU_WAIT: begin
                    if (dmem_rvalid)
                        state <= LSU_IDLE;
                end
                default: state <= LSU_IDLE;
            endcase
        end
    end

    load_align u_load_align (
        .func3     (MEM_docoder_func3),
        .addr_lsb  (MEM_alu_result[1:0]),
        .rdata     (dmem_rdata),
        .load_data (load_word)
    );

    // MEM/WB register: bubble while stalled or misaligned. Load data is only
    // captured on the rvalid that completes a load so stray bus values
    // (including a late rvalid after reset) never reach WB.
    always_ff @(posedge clk) begin
        if (rst) begin
            WB_controller_mux_rd     <= 1'b0;
            WB_controller_regfile_en <= 1'b0;
            WB_decoder_rd_index      <= 5'd0;
            WB_alu_result            <= 32'd0;
            WB_load_data             <= 32'd0;
        end else begin
            WB_controller_mux_rd     <= MEM_controller_mux_rd;
            WB_controller_regfile_en <= MEM_controller_regfile_en & ~mem_stall & ~misaligned;
            WB_decoder_rd_index      <= MEM_decoder_rd_index;
            WB_alu_result            <= MEM_alu_result;
            WB_load_data             <= (is_load & load_done) ? load_word : 32'd0;
        end
    end

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Randomised scoreboard bench for mem_stage_lsu with a byte-level memory
// reference model and a latency-programmable memory responder.
module tb_mem_stage_lsu;

    localparam int ADDR_W = 32;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [3:0]        dm_en = '0;
    logic              mux_rd = 1'b0;
    logic              ren = 1'b0;
    logic [2:0]        f3 = '0;
    logic [4:0]        rd_idx = '0;
    logic [31:0]       alu = '0;
    logic [31:0]       rs2 = '0;
    logic              dmem_req, dmem_we;
    logic [3:0]        dmem_wstrb;
    logic [ADDR_W-1:0] dmem_addr;
    logic [31:0]       dmem_wdata;
    logic              dmem_gnt = 1'b0;
    logic              dmem_rvalid = 1'b0;
    logic [31:0]       dmem_rdata = '0;
    logic              mem_stall, misalign_err;
    logic              wb_mux_rd, wb_ren;
    logic [4:0]        wb_rd;
    logic [31:0]       wb_alu, wb_ld;

    mem_stage_lsu #(.ADDR_W(ADDR_W)) dut (
        .clk                      (clk),
        .rst                      (rst),
        .MEM_controller_dm_en     (dm_en),
        .MEM_controller_mux_rd    (mux_rd),
        .MEM_controller_regfile_en(ren),
        .MEM_docoder_func3        (f3),
        .MEM_decoder_rd_index     (rd_idx),
        .MEM_alu_result           (alu),
        .MEM_write_data           (rs2),
        .dmem_req                 (dmem_req),
        .dmem_we                  (dmem_we),
        .dmem_wstrb               (dmem_wstrb),
        .dmem_addr                (dmem_addr),
        .dmem_wdata               (dmem_wdata),
        .dmem_gnt                 (dmem_gnt),
        .dmem_rvalid              (dmem_rvalid),
        .dmem_rdata               (dmem_rdata),
        .mem_stall                (mem_stall),
        .misalign_err             (misalign_err),
        .WB_controller_mux_rd     (wb_mux_rd),
        .WB_controller_regfile_en (wb_ren),
        .WB_decoder_rd_index      (wb_rd),
        .WB_alu_result            (wb_alu),
        .WB_load_data             (wb_ld)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passed = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    endtask

    typedef struct { logic [4:0] rd; logic mux_rd; logic [31:0] val; } wb_exp_t;
    typedef struct { logic [31:0] addr; logic [3:0] strb; logic [31:0] data; } st_exp_t;

    wb_exp_t     wb_q[$];
    st_exp_t     st_q[$];
    logic [31:0] mem_ref [256];
    logic [31:0] mem_dut [256];

    int          gnt_delay = 0;
    int          rvalid_delay = 1;
    logic        exp_we = 1'b0;
    logic [31:0] last_wdata = '0;
    logic [3:0]  last_wstrb = '0;

    // ---------------- reference model ----------------
    function automatic int nbytes(input logic [2:0] c);
        if (c[1:0] == 2'b00) return 1;
        if (c[1:0] == 2'b01) return 2;
        return 4;
    endfunction

    function automatic logic [31:0] ref_load(input logic [2:0] c, input logic [31:0] a);
        int          n    = nbytes(c);
        int          base = int'(a[1:0]);
        logic [31:0] w    = mem_ref[a[9:2]];
        logic [31:0] r    = '0;
        for (int k = 0; k < n; k++) r[8*k +: 8] = w[8*(base+k) +: 8];
        if (!c[2] && n < 4 && r[8*n-1]) r = r | ~((32'd1 << (8*n)) - 32'd1);
        return r;
    endfunction

    task automatic ref_store(input logic [2:0] c, input logic [31:0] a, input logic [31:0] d,
                             output st_exp_t e);
        int n    = nbytes(c);
        int base = int'(a[1:0]);
        e.addr = {a[31:2], 2'b00};
        e.strb = '0;
        e.data = '0;
        for (int k = 0; k < n; k++) begin
            e.strb[base+k]              = 1'b1;
            e.data[8*(base+k) +: 8]     = d[8*k +: 8];
            mem_ref[a[9:2]][8*(base+k) +: 8] = d[8*k +: 8];
        end
    endtask

    function automatic logic [31:0] strb_mask(input logic [3:0] s);
        logic [31:0] m = '0;
        for (int l = 0; l < 4; l++) if (s[l]) m[8*l +: 8] = 8'hFF;
        return m;
    endfunction

    // ---------------- memory responder ----------------
    int          wait_left = 0;
    int          rv_left = 0;
    logic        req_open = 1'b0;
    logic [7:0]  ld_idx = '0;
    logic [31:0] h_addr, h_wdata;
    logic [4:0]  h_ctl;
    st_exp_t     se;

    always @(negedge clk) begin
        dmem_gnt    = 1'b0;
        dmem_rvalid = 1'b0;
        dmem_rdata  = $urandom;
        if (rv_left > 0) begin
            rv_left--;
            if (rv_left == 0) begin
                dmem_rvalid = 1'b1;
                dmem_rdata  = mem_dut[ld_idx];
            end
        end
        if (rst) begin
            req_open = 1'b0;
        end else if (dmem_req) begin
            if (!req_open) begin
                req_open  = 1'b1;
                wait_left = gnt_delay;
                h_addr    = dmem_addr;
                h_wdata   = dmem_wdata;
                h_ctl     = {dmem_we, dmem_wstrb};
                chk("dmem_we", {31'd0, dmem_we}, {31'd0, exp_we});
            end else begin
                chk("req_hold_addr", dmem_addr, h_addr);
                chk("req_hold_wdata", dmem_wdata, h_wdata);
                chk("req_hold_ctl", {27'd0, dmem_we, dmem_wstrb}, {27'd0, h_ctl});
            end
            if (wait_left == 0) begin
                dmem_gnt = 1'b1;
                req_open = 1'b0;
                if (dmem_we) begin
                    last_wdata = dmem_wdata;
                    last_wstrb = dmem_wstrb;
                    if (st_q.size() == 0) begin
                        chk("store_unexpected", {31'd0, dmem_we}, 32'd0);
                    end else begin
                        se = st_q.pop_front();
                        chk("store_addr", dmem_addr, se.addr);
                        chk("store_wstrb", {28'd0, dmem_wstrb}, {28'd0, se.strb});
                        chk("store_wdata", dmem_wdata & strb_mask(se.strb), se.data);
                    end
                    for (int l = 0; l < 4; l++)
                        if (dmem_wstrb[l]) mem_dut[dmem_addr[9:2]][8*l +: 8] = dmem_wdata[8*l +: 8];
                end else begin
                    ld_idx  = dmem_addr[9:2];
                    rv_left = rvalid_delay;
                end
            end else begin
                wait_left--;
            end
        end
    end

    // ---------------- WB monitor ----------------
    wb_exp_t mon_e;

    always @(negedge clk) begin
        if (!rst && wb_ren) begin
            if (wb_q.size() == 0) begin
                chk("wb_spurious_write", {31'd0, wb_ren}, 32'd0);
            end else begin
                mon_e = wb_q.pop_front();
                chk("wb_rd", {27'd0, wb_rd}, {27'd0, mon_e.rd});
                chk("wb_mux_rd", {31'd0, wb_mux_rd}, {31'd0, mon_e.mux_rd});
                chk("wb_value", wb_mux_rd ? wb_ld : wb_alu, mon_e.val);
            end
        end
    end

    // ---------------- driver ----------------
    // Called at posedge+1; returns at posedge+1 after the completion edge.
    task automatic issue(input logic [3:0] i_dm_en, input logic i_mux_rd, input logic i_ren,
                         input logic [2:0] i_f3, input logic [4:0] i_rd, input logic [31:0] i_alu,
                         input logic [31:0] i_rs2, input int gd, input int rvd, output int stalls);
        logic    st  = (i_dm_en != 4'd0);
        logic    ld  = i_mux_rd & i_ren;
        logic    acc = st | ld;
        int      n   = nbytes(i_f3);
        logic    mis = acc && ((n == 2 && i_alu[0]) || (n == 4 && i_alu[1:0] != 2'b00));
        int      exp_stall;
        wb_exp_t we;
        st_exp_t e;
        bit      timed_out = 0;

        exp_stall = (!acc || mis) ? 0 : (st ? gd : gd + rvd);
        if (i_ren && !mis) begin
            we.rd     = i_rd;
            we.mux_rd = i_mux_rd;
            we.val    = i_mux_rd ? ref_load(i_f3, i_alu) : i_alu;
            wb_q.push_back(we);
        end
        if (st && !mis) begin
            ref_store(i_f3, i_alu, i_rs2, e);
            st_q.push_back(e);
        end
        gnt_delay    = gd;
        rvalid_delay = rvd;
        exp_we       = st;
        dm_en = i_dm_en; mux_rd = i_mux_rd; ren = i_ren; f3 = i_f3;
        rd_idx = i_rd; alu = i_alu; rs2 = i_rs2;

        stalls = 0;
        forever begin
            @(negedge clk); #1;
            chk("misalign_err", {31'd0, misalign_err}, {31'd0, mis});
            if (mis) chk("req_on_misalign", {31'd0, dmem_req}, 32'd0);
            if (!mem_stall) break;
            stalls++;
            if (stalls > 40) begin
                chk("stall_timeout", stalls, exp_stall);
                timed_out = 1;
                break;
            end
        end
        @(posedge clk); #1;
        if (!timed_out) chk("stall_cycles", stalls, exp_stall);
    endtask

    task automatic nop();
        int s;
        issue(4'd0, 1'b0, 1'b0, 3'd0, 5'd0, 32'd0, 32'd0, 0, 1, s);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          s;
        int          kind, n, base, m;
        logic [2:0]  lf3;
        logic [31:0] a, w;
        logic [2:0]  ld_codes [7] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101, 3'b011, 3'b110};

        for (int i = 0; i < 256; i++) begin
            w = $urandom;
            mem_ref[i] = w;
            mem_dut[i] = w;
        end
        mem_ref[8'h40] = 32'h80FF_1234; mem_dut[8'h40] = 32'h80FF_1234;
        mem_ref[8'hC0] = 32'hBEEF_0000; mem_dut[8'hC0] = 32'hBEEF_0000;

        // Reset values
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk); #1;
        chk("rst_dmem_req", {31'd0, dmem_req}, 32'd0);
        chk("rst_mem_stall", {31'd0, mem_stall}, 32'd0);
        chk("rst_misalign", {31'd0, misalign_err}, 32'd0);
        chk("rst_wb_ctl", {29'd0, wb_mux_rd, wb_ren, 1'b0}, 32'd0);
        chk("rst_wb_rd", {27'd0, wb_rd}, 32'd0);
        chk("rst_wb_alu", wb_alu, 32'd0);
        chk("rst_wb_ld", wb_ld, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // LB sign-extended from byte 3
        issue(4'd0, 1'b1, 1'b1, 3'b000, 5'd5, 32'h0000_0103, 32'd0, 0, 1, s);
        chk("lb_data", wb_ld, 32'hFFFF_FF80);
        chk("lb_ren", {31'd0, wb_ren}, 32'd1);

        // SB into lane 2, immediate grant
        issue(4'b0100, 1'b0, 1'b0, 3'b000, 5'd0, 32'h0000_0202, 32'h0000_00AB, 0, 1, s);
        chk("sb_wdata", last_wdata, 32'h00AB_0000);
        chk("sb_wstrb", {28'd0, last_wstrb}, 32'h4);
        chk("sb_stalls", s, 0);

        // LW with a slow grant and slow data
        issue(4'd0, 1'b1, 1'b1, 3'b010, 5'd7, 32'h0000_0010, 32'd0, 3, 2, s);
        chk("lw_slow_stalls", s, 5);

        // Misaligned LH
        issue(4'd0, 1'b1, 1'b1, 3'b001, 5'd9, 32'h0000_0101, 32'd0, 0, 1, s);
        chk("lh_mis_wb_ren", {31'd0, wb_ren}, 32'd0);

        // SW then LHU back to back
        issue(4'b1111, 1'b0, 1'b0, 3'b010, 5'd0, 32'h0000_0304, 32'h1357_9BDF, 0, 1, s);
        chk("sw_stalls", s, 0);
        issue(4'd0, 1'b1, 1'b1, 3'b101, 5'd11, 32'h0000_0302, 32'd0, 0, 1, s);
        chk("lhu_stalls", s, 1);
        chk("lhu_data", wb_ld, 32'h0000_BEEF);

        // Reset while a load waits for rvalid; the late rvalid must be ignored
        gnt_delay = 0; rvalid_delay = 3; exp_we = 1'b0;
        dm_en = 4'd0; mux_rd = 1'b1; ren = 1'b1; f3 = 3'b010; rd_idx = 5'd3;
        alu = 32'h0000_0020; rs2 = 32'd0;
        @(negedge clk); #1;
        chk("rstw_first_stall", {31'd0, mem_stall}, 32'd1);
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk); #1;
        chk("rstw_req_dropped", {31'd0, dmem_req}, 32'd0);
        chk("rstw_no_stall", {31'd0, mem_stall}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        dm_en = 4'd0; mux_rd = 1'b0; ren = 1'b0; f3 = 3'd0; rd_idx = 5'd0; alu = 32'd0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk); #1;
            chk("rstw_req_idle", {31'd0, dmem_req}, 32'd0);
            chk("rstw_wb_ctl", {30'd0, wb_mux_rd, wb_ren}, 32'd0);
            chk("rstw_wb_rd", {27'd0, wb_rd}, 32'd0);
            chk("rstw_wb_alu", wb_alu, 32'd0);
            chk("rstw_wb_ld", wb_ld, 32'd0);
        end
        @(posedge clk); #1;
        issue(4'd0, 1'b0, 1'b1, 3'd0, 5'd4, 32'hCAFE_0001, 32'd0, 0, 1, s);
        chk("post_rst_alu", wb_alu, 32'hCAFE_0001);

        // Randomised traffic
        for (int t = 0; t < 300; t++) begin
            kind = $urandom_range(0, 3);
            a    = {22'd0, 10'($urandom_range(0, 1023))};
            case (kind)
                0: issue(4'd0, 1'b0, 1'($urandom_range(0, 1)), 3'($urandom), 5'($urandom),
                         $urandom, $urandom, 0, 1, s);
                1, 2: begin
                    lf3 = ld_codes[$urandom_range(0, 6)];
                    issue(4'd0, 1'b1, 1'b1, lf3, 5'($urandom), a, $urandom,
                          $urandom_range(0, 3), $urandom_range(1, 3), s);
                end
                default: begin
                    lf3  = 3'($urandom_range(0, 2));
                    n    = nbytes(lf3);
                    base = int'(a[1:0]);
                    m    = ((1 << n) - 1) << base;
                    issue(4'(m), 1'b0, 1'b0, lf3, 5'd0, a, $urandom,
                          $urandom_range(0, 3), 1, s);
                end
            endcase
        end

        nop();
        repeat (3) @(negedge clk);
        #1;
        chk("wb_queue_drained", wb_q.size(), 0);
        chk("store_queue_drained", st_q.size(), 0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
